pulse_gate_ctrl: RTL and testbench
==================================

PULSE_GATE_CTRL -- requirements
Module: pulse_gate_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the counter value sampled and reported.
REQ-002 SHALL have parameter GATE_W, default 24, width of the gate-length field.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, level request to begin a measurement; sampled only in IDLE.
REQ-006 SHALL have port continuous, input, 1, repeat windows until abort; sampled at handshake.
REQ-007 SHALL have port abort, input, 1, terminate the current operation.
REQ-008 SHALL have port gate_len, input, GATE_W, window length in clk cycles; latched on leaving IDLE.
REQ-009 SHALL have port en_count, output, 1, enable to the external pulse counter; low clears that counter.
REQ-010 SHALL have port count_in, input, CNT_W, the external counter's running value.
REQ-011 SHALL have port result, output, CNT_W, the captured window count.
REQ-012 SHALL have port result_valid, output, 1, result is valid.
REQ-013 SHALL have port result_ready, input, 1, consumer accepts result.
REQ-014 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-015 SHALL have port ovf, output, 1, counter saturated in the captured window.

Function
REQ-016 SHALL implement the FSM states IDLE, ARM, GATE, CAPTURE and HOLD; all outputs are registered.
REQ-017 SHALL go IDLE->ARM on start=1; in ARM, en_count=0 for exactly one cycle to clear the counter.
REQ-018 SHALL go ARM->GATE; en_count=1 for exactly max(gate_len,1) cycles; gate_len=0 is treated as 1.
REQ-019 SHALL keep en_count=1 during the single CAPTURE cycle and register count_in into result in that cycle.
REQ-020 SHALL make result_valid=1 in the cycle after CAPTURE (first HOLD cycle), with en_count=0 throughout HOLD.
REQ-021 SHALL hold result, result_valid and ovf stable in HOLD until result_valid&&result_ready.
REQ-022 SHALL, on handshake, drop result_valid next cycle and go to ARM if continuous=1, else to IDLE.
REQ-023 SHALL ignore start outside IDLE and ignore changes on gate_len after it is latched.
REQ-024 SHALL make abort=1 in any state go to IDLE next cycle with en_count=0 and result_valid=0; abort has priority over the handshake and over start.
REQ-025 SHALL use a GATE_W-bit down-counter for the window length, with no wrap at the maximum gate_len.
REQ-026 SHALL never alter result except in CAPTURE.

Reset
REQ-027 SHALL apply the following while rst=1 at a clock edge: state=IDLE, en_count=0, result=0, result_valid=0, busy=0, ovf=0, and window counter=0.
REQ-028 SHALL, on reset mid-window, discard the window and produce no result_valid.

Configuration
REQ-029 SHALL use macro PULSE_GATE_OVF_EN to select overflow detection.
REQ-030 SHALL, when PULSE_GATE_OVF_EN is defined, set a sticky flag if count_in equals all-ones in any GATE or CAPTURE cycle; that flag is copied to ovf at CAPTURE, and result is then all-ones. The flag clears in ARM.
REQ-031 SHALL, when PULSE_GATE_OVF_EN is undefined, tie ovf to 0 and make result the raw count_in sampled at CAPTURE.

Verification
REQ-032 SHALL verify gate_len=4, start pulse at cycle 0, count_in=7 in CAPTURE, result_ready=1 -> en_count low cycle 1, high cycles 2-6, result=7, result_valid high cycle 7 only.
REQ-033 SHALL verify result_ready low for 3 cycles in HOLD -> result_valid stays high and result stays constant for 3 cycles, then drops the cycle after the handshake.
REQ-034 SHALL verify continuous=1 at handshake -> next cycle ARM (en_count=0 for 1 cycle), then a new 4-cycle GATE; busy stays high.
REQ-035 SHALL verify abort asserted in the 2nd GATE cycle -> en_count=0 and busy=0 next cycle, and result_valid never asserts.
REQ-036 SHALL verify count_in=16'hFFFF during GATE -> with the macro, ovf=1 and result=16'hFFFF; without the macro, ovf=0.
REQ-037 SHALL verify gate_len=0 -> en_count high for exactly 2 cycles (1 GATE + CAPTURE); rst in GATE -> IDLE with all outputs at their reset values.

Source files
------------

// File: rtl/pulse_gate_ctrl.sv
`default_nettype none
// pulse_gate_ctrl: gates an external pulse counter for a programmable window and hands the count off.
// Optional overflow detection is built when PULSE_GATE_OVF_EN is defined.
module pulse_gate_ctrl #(
  parameter int CNT_W  = 16,
  parameter int GATE_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  input  logic              abort,
  input  logic [GATE_W-1:0] gate_len,
  output logic              en_count,
  input  logic [CNT_W-1:0]  count_in,
  output logic [CNT_W-1:0]  result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              busy,
  output logic              ovf
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_GATE    = 3'd2,
    S_CAPTURE = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  localparam logic [GATE_W-1:0] c_win_one = GATE_W'(1);

  state_t            r_state;
  state_t            w_next;
  logic [GATE_W-1:0] r_len;
  logic [GATE_W-1:0] r_win;
  logic              w_handshake;
  logic              w_cap_ovf;
  logic [CNT_W-1:0]  w_cap_val;

  // result_valid is high for the whole of HOLD, so the handshake reduces to ready in HOLD
  assign w_handshake = (r_state == S_HOLD) && result_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (start) w_next = S_ARM;
        S_ARM:     w_next = S_GATE;
        S_GATE:    if (r_win <= c_win_one) w_next = S_CAPTURE;
        S_CAPTURE: w_next = S_HOLD;
        S_HOLD:    if (w_handshake) w_next = continuous ? S_ARM : S_IDLE;
        default:   w_next = S_IDLE;
      endcase
    end
  end

  // Window length is latched once per start and reused by every continuous window
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len <= '0;
      r_win <= '0;
    end else begin
      if (r_state == S_IDLE && w_next == S_ARM) r_len <= gate_len;
      if (r_state == S_ARM)
        r_win <= (r_len == '0) ? c_win_one : r_len;
      else if (r_state == S_GATE && r_win != '0)
        r_win <= r_win - c_win_one;
    end
  end

`ifdef PULSE_GATE_OVF_EN
  logic r_sat;
  logic w_sat_now;

  assign w_sat_now = &count_in;

  always_ff @(posedge clk) begin
    if (rst)
      r_sat <= 1'b0;
    else if (r_state == S_ARM)
      r_sat <= 1'b0;
    else if ((r_state == S_GATE || r_state == S_CAPTURE) && w_sat_now)
      r_sat <= 1'b1;
  end

  // The capture cycle itself counts toward saturation, hence the OR with the live value
  assign w_cap_ovf = r_sat | w_sat_now;
  assign w_cap_val = w_cap_ovf ? {CNT_W{1'b1}} : count_in;
`else
  assign w_cap_ovf = 1'b0;
  assign w_cap_val = count_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      en_count     <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      ovf          <= 1'b0;
    end else begin
      en_count     <= (w_next == S_GATE) || (w_next == S_CAPTURE);
      busy         <= (w_next != S_IDLE);
      result_valid <= (w_next == S_HOLD);
      if (r_state == S_CAPTURE && !abort) begin
        result <= w_cap_val;
        ovf    <= w_cap_ovf;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pulse_gate_ctrl.sv
`default_nettype none
// tb_pulse_gate_ctrl: directed, self-checking bench for pulse_gate_ctrl.
module tb_pulse_gate_ctrl;

  localparam int CNT_W  = 16;
  localparam int GATE_W = 24;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              continuous;
  logic              abort;
  logic [GATE_W-1:0] gate_len;
  logic              en_count;
  logic [CNT_W-1:0]  count_in;
  logic [CNT_W-1:0]  result;
  logic              result_valid;
  logic              result_ready;
  logic              busy;
  logic              ovf;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  pulse_gate_ctrl #(.CNT_W(CNT_W), .GATE_W(GATE_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .continuous   (continuous),
    .abort        (abort),
    .gate_len     (gate_len),
    .en_count     (en_count),
    .count_in     (count_in),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy),
    .ovf          (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; continuous = 1'b0; abort = 1'b0;
    gate_len = '0; count_in = '0; result_ready = 1'b0;
    tick(); tick();
    chk("rst_en", en_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    tick();

    // Basic window: gate_len=4, start in cycle 0
    start = 1'b1; gate_len = 24'd4; result_ready = 1'b1;
    chk("b_c0_busy", busy, 0);
    tick(); start = 1'b0;
    chk("b_arm_en", en_count, 0);
    chk("b_arm_busy", busy, 1);
    for (int c = 2; c <= 6; c++) begin
      tick();
      chk($sformatf("b_en_c%0d", c), en_count, 1);
      chk($sformatf("b_valid_c%0d", c), result_valid, 0);
      if (c == 6) count_in = 16'd7;
    end
    tick(); count_in = 16'd2;
    chk("b_hold_valid", result_valid, 1);
    chk("b_hold_result", result, 16'd7);
    chk("b_hold_en", en_count, 0);
    chk("b_hold_busy", busy, 1);
    tick();
    chk("b_done_valid", result_valid, 0);
    chk("b_done_busy", busy, 0);
    chk("b_done_result", result, 16'd7);

    // Backpressure: ready low for three HOLD cycles; gate_len=2
    start = 1'b1; gate_len = 24'd2; result_ready = 1'b0;
    tick(); start = 1'b0;
    tick(); tick();
    chk("bp_gate_en", en_count, 1);
    tick(); count_in = 16'd3;
    chk("bp_cap_en", en_count, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      count_in = 16'(9 + i);
      chk($sformatf("bp_valid_%0d", i), result_valid, 1);
      chk($sformatf("bp_result_%0d", i), result, 16'd3);
      if (i == 2) result_ready = 1'b1;
      tick();
    end
    chk("bp_drop_valid", result_valid, 0);
    chk("bp_drop_result", result, 16'd3);

    // Continuous: second window reuses the latched length even if gate_len changes
    start = 1'b1; continuous = 1'b1; gate_len = 24'd4; result_ready = 1'b1; count_in = 16'd1;
    tick(); start = 1'b0; gate_len = 24'd9;
    for (int c = 0; c < 5; c++) tick();
    count_in = 16'd11;
    tick();
    chk("ct_hold1_valid", result_valid, 1);
    chk("ct_hold1_result", result, 16'd11);
    tick();
    chk("ct_arm_en", en_count, 0);
    chk("ct_arm_busy", busy, 1);
    chk("ct_arm_valid", result_valid, 0);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("ct_en_%0d", c), en_count, 1);
      chk($sformatf("ct_busy_%0d", c), busy, 1);
    end
    count_in = 16'd4;
    tick();
    chk("ct_hold2_valid", result_valid, 1);
    chk("ct_hold2_en", en_count, 0);
    chk("ct_hold2_result", result, 16'd4);
    // Abort wins over handshake with continuous set
    abort = 1'b1;
    tick(); abort = 1'b0; continuous = 1'b0;
    chk("ct_abort_busy", busy, 0);
    chk("ct_abort_valid", result_valid, 0);

    // Abort in the second GATE cycle
    start = 1'b1; gate_len = 24'd4;
    tick(); start = 1'b0;
    tick();
    tick(); abort = 1'b1;
    tick(); abort = 1'b0;
    chk("ab_en", en_count, 0);
    chk("ab_busy", busy, 0);
    begin
      int seen_valid = 0;
      for (int c = 0; c < 8; c++) begin
        if (result_valid) seen_valid++;
        tick();
      end
      chk("ab_no_valid", seen_valid, 0);
    end
    chk("ab_result_kept", result, 16'd4);

    // Saturation seen during GATE, counter value lower at capture
    start = 1'b1; gate_len = 24'd3;
    tick(); start = 1'b0;
    tick(); count_in = 16'hFFFF;
    tick(); count_in = 16'd5;
    tick(); tick();
    chk("of_cap_en", en_count, 1);
    tick();
    chk("of_valid", result_valid, 1);
`ifdef PULSE_GATE_OVF_EN
    chk("of_ovf", ovf, 1);
    chk("of_result", result, 16'hFFFF);
`else
    chk("of_ovf", ovf, 0);
    chk("of_result", result, 16'd5);
`endif
    tick();

    // gate_len=0 behaves as 1: en_count high for exactly two cycles
    start = 1'b1; gate_len = 24'd0; count_in = 16'd1;
    begin
      int en_cycles = 0;
      for (int c = 0; c < 8; c++) begin
        tick(); start = 1'b0;
        if (en_count) en_cycles++;
      end
      chk("z_en_cycles", en_cycles, 2);
    end
    chk("z_result", result, 16'd1);
    chk("z_ovf_cleared", ovf, 0);
    chk("z_idle", busy, 0);

    // Reset in the middle of GATE
    start = 1'b1; gate_len = 24'd6; count_in = 16'd8;
    tick(); start = 1'b0;
    tick(); tick();
    chk("r_gate_en", en_count, 1);
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk("r_en", en_count, 0);
    chk("r_busy", busy, 0);
    chk("r_valid", result_valid, 0);
    chk("r_result", result, 0);
    chk("r_ovf", ovf, 0);
    begin
      int seen_valid = 0;
      for (int c = 0; c < 10; c++) begin
        tick();
        if (result_valid || en_count) seen_valid++;
      end
      chk("r_no_resume", seen_valid, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
